// File: rtl/proc_pkg.sv
// proc_pkg: shared state and entry types for the memory fetch path.
// Entry widths follow the default ADDR_W/DATA_W of mem_fetch_unit.
package proc_pkg;

  localparam int FETCH_ADDR_W = 5;
  localparam int FETCH_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_DATA_W-1:0] data;
    logic [FETCH_ADDR_W-1:0] addr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO of fetch entries.
// Head output comes straight from storage and read-pointer registers.
module fetch_fifo
  import proc_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            do_pop;
  logic            do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop at full frees the slot the push lands in.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mem_fetch_unit.sv
// mem_fetch_unit: credit-based sequential fetch from a sync memory.
// MEM_FETCH_JUMP_EN adds the jmp_valid/jmp_addr redirect path.
module mem_fetch_unit
  import proc_pkg::*;
#(
  parameter int ADDR_W    = FETCH_ADDR_W,
  parameter int DATA_W    = FETCH_DATA_W,
  parameter int DEPTH     = 4,
  parameter int LAST_ADDR = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              busy,
  output logic              done
`ifdef MEM_FETCH_JUMP_EN
  ,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_addr
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  fetch_state_t      state;
  fetch_state_t      state_nx;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_pp;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push;
  logic              credit;
  logic              inflight;
  logic              epoch;
  logic              rd_epoch;
  logic              jmp_take;
  logic              start_take;
  logic [ADDR_W-1:0] jmp_target;
  logic [ADDR_W-1:0] rd_addr;
  fetch_entry_t      wdata;
  fetch_entry_t      head;

`ifdef MEM_FETCH_JUMP_EN
  assign jmp_take   = jmp_valid &
                      ((state == FETCH) | (state == DRAIN));
  assign jmp_target = jmp_addr;
`else
  assign jmp_take   = 1'b0;
  assign jmp_target = '0;
`endif

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (jmp_take),
    .wdata (wdata),
    .head  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  assign wdata.data  = DIN;
  assign wdata.addr  = rd_addr;
  assign instr       = head.data;
  assign instr_addr  = head.addr;
  assign instr_valid = ~empty;
  assign busy        = (state == FETCH) | (state == DRAIN);
  assign done        = (state == DONE);

  always_comb begin
    pop        = instr_valid & instr_ready;
    count_pp   = count - CW'(pop);
    credit     = (count_pp + CW'(inflight)) < CW'(DEPTH);
    mem_rd     = (state == FETCH) & credit & ~(full & ~pop);
    // Responses tagged with an old epoch were overtaken by a jump.
    push       = inflight & (rd_epoch == epoch);
    start_take = start & ((state == IDLE) | (state == DONE));
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (start) state_nx = FETCH;
      FETCH: if (mem_rd && addr == LAST) state_nx = DRAIN;
      DRAIN: if (!inflight && count_pp == '0) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (jmp_take) state_nx = FETCH;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      inflight <= 1'b0;
      rd_addr  <= '0;
      rd_epoch <= 1'b0;
      epoch    <= 1'b0;
    end else begin
      state    <= state_nx;
      inflight <= mem_rd;
      if (mem_rd) begin
        rd_addr  <= addr;
        rd_epoch <= epoch;
      end
      if (jmp_take) epoch <= ~epoch;
      if (jmp_take) addr <= jmp_target;
      else if (start_take) addr <= '0;
      else if (mem_rd && addr != LAST) addr <= addr + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_fetch_unit.sv
// tb_mem_fetch_unit: vector table of fetch runs plus reset and jump cases.
// Expected words are queued at start/jump and popped on each transfer.
module tb_mem_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  addr;
  logic        mem_rd;
  logic [15:0] DIN;
  logic [15:0] instr;
  logic [4:0]  instr_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic        busy;
  logic        done;
`ifdef MEM_FETCH_JUMP_EN
  logic        jmp_valid;
  logic [4:0]  jmp_addr;
`endif

  mem_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .addr        (addr),
    .mem_rd      (mem_rd),
    .DIN         (DIN),
    .instr       (instr),
    .instr_addr  (instr_addr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .busy        (busy),
    .done        (done)
`ifdef MEM_FETCH_JUMP_EN
    ,
    .jmp_valid   (jmp_valid),
    .jmp_addr    (jmp_addr)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) DIN <= 16'hA000 + {11'd0, addr};
  end

  typedef struct {
    int          mode;
    int          jcyc;
    int          exp_words;
    logic [15:0] exp_last;
    int          exp_last_cyc;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic [4:0]  a;
  } exp_t;

  exp_t        q[$];
  vec_t        vecs[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc, issued, delivered, xfers;
  int          last_xfer_cyc, rd_exp, mode;
  bit          lat_en, hold_prev, jmp_now;
  logic [20:0] hold_val;
  logic [15:0] last_word;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  name, act, exp, $time);
  endtask

  function automatic logic ready_for(int m, int c);
    case (m)
      1: return !(c >= 3 && c <= 12);
      2: return 1'($urandom_range(0, 1));
      4: return c > 5;
      default: return 1'b1;
    endcase
  endfunction

  task automatic fill_q(input int from);
    q.delete();
    for (int i = from; i < 32; i++)
      q.push_back('{data: 16'(16'hA000 + i), a: 5'(i)});
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_instr_addr"}, instr_addr, 0);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Sample at negedge, then advance to just after the next posedge.
  task automatic cycle();
    logic xfer;
    exp_t e;
    @(negedge clk);
    xfer = instr_valid & instr_ready;
    if (lat_en && cyc == 1) chk("lat_mem_rd", mem_rd, 1);
    if (lat_en && cyc == 2) chk("lat_valid_c2", instr_valid, 0);
    if (lat_en && cyc == 3) chk("lat_valid_c3", instr_valid, 1);
    if (lat_en && mode == 1 && cyc == 12)
      chk("bp_outstanding", issued - delivered, DEPTH);
    if (hold_prev) begin
      chk("hold_valid", instr_valid, 1);
      chk("hold_word", {instr_addr, instr}, hold_val);
    end
    if (mem_rd) begin
      chk("credit", (issued - delivered - int'(xfer) + 1) <= DEPTH, 1);
      chk("rd_addr", addr, rd_exp);
      rd_exp++;
      issued++;
    end
    if (xfer) begin
      chk("word_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("instr", instr, e.data);
        chk("instr_addr", instr_addr, e.a);
      end
      delivered++;
      xfers++;
      last_word = instr;
      last_xfer_cyc = cyc;
    end
    hold_prev = instr_valid & ~instr_ready & ~jmp_now;
    hold_val = {instr_addr, instr};
    @(posedge clk);
    #1;
    cyc++;
    instr_ready = ready_for(mode, cyc);
  endtask

  task automatic clear_counts();
    cyc = 0;
    issued = 0;
    delivered = 0;
    xfers = 0;
    rd_exp = 0;
    last_xfer_cyc = -1;
    hold_prev = 0;
  endtask

  task automatic run(input vec_t v);
    mode = v.mode;
    lat_en = 1;
    clear_counts();
    fill_q(0);
    instr_ready = ready_for(mode, 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    while (!done && cyc < 400) begin
      jmp_now = 0;
      if (v.mode == 3 && (cyc == 5 || cyc == 20)) start = 1'b1;
`ifdef MEM_FETCH_JUMP_EN
      if (cyc == v.jcyc) begin
        jmp_valid = 1'b1;
        jmp_addr = 5'd20;
        jmp_now = 1;
      end
`endif
      cycle();
      start = 1'b0;
`ifdef MEM_FETCH_JUMP_EN
      if (jmp_now) begin
        jmp_valid = 1'b0;
        fill_q(20);
        rd_exp = 20;
        delivered = issued;
      end
`endif
      jmp_now = 0;
    end
    chk("run_timeout", cyc < 400, 1);
    chk("words", xfers, v.exp_words);
    chk("last_word", last_word, v.exp_last);
    chk("queue_empty", q.size(), 0);
    chk("done_latency", cyc, last_xfer_cyc + 1);
    chk("done_addr", addr, 31);
    chk("done_busy", busy, 0);
    if (v.exp_last_cyc >= 0)
      chk("throughput", last_xfer_cyc, v.exp_last_cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{0, -1, 32, 16'hA01F, 34});
    vecs.push_back('{1, -1, 32, 16'hA01F, -1});
    vecs.push_back('{2, -1, 32, 16'hA01F, -1});
    vecs.push_back('{3, -1, 32, 16'hA01F, 34});
`ifdef MEM_FETCH_JUMP_EN
    vecs.push_back('{4, 5, 12, 16'hA01F, -1});
    jmp_valid = 1'b0;
    jmp_addr = '0;
`endif
    reset = 1'b1;
    start = 1'b0;
    instr_ready = 1'b0;
    jmp_now = 0;
    last_word = '0;
    mode = 0;
    lat_en = 0;
    clear_counts();
    #3;
    check_reset("rst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    fill_q(0);
    instr_ready = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    while (xfers < 10 && cyc < 100) cycle();
    chk("mid_reached", xfers, 10);
    reset = 1'b1;
    #1;
    check_reset("mid");
    q.delete();
    clear_counts();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) begin
      cycle();
      chk("post_rst_quiet", {instr_valid, mem_rd, busy}, 0);
    end

    foreach (vecs[i]) run(vecs[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
